// File: rtl/input_conditioner.sv
// input_conditioner: front-end conditioning for the rotary CLK/DT contacts
// and the push button. Each channel is brought into the clk domain with a
// 2-flop synchroniser, then debounced by a stability counter that only lets
// clean_out follow the synchronised level after STABLE_CYCLES consecutive
// differing samples. Registered single-cycle rise/fall strobes accompany
// every clean_out change.
//
// Optional build macro: INPUT_CONDITIONER_GLITCH_CNT_EN
//   defined   -> glitch_count counts cycles in which at least one channel
//                abandoned a debounce in progress (saturating at 255).
//   undefined -> glitch_count is tied to 8'h00 and no counter exists.
//
// Interface timing: there is no valid/ready handshake. Every output is a
// free-running registered level or one-cycle strobe; consumers sample it
// on every clk edge.
module input_conditioner #(
    parameter int                  CHANNELS      = 3,
    parameter int                  STABLE_CYCLES = 5000,
    parameter int                  CNT_W         = 13,
    parameter logic [CHANNELS-1:0] RESET_LEVEL   = 3'b011
) (
    input  logic                clk,
    input  logic                res_n,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] clean_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic [7:0]          glitch_count
);

    // Final count value: the sample that reaches it commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] r_s1;
    logic [CHANNELS-1:0] r_s2;
    logic [CHANNELS-1:0] r_clean;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

    // Two-flop synchroniser; idles at the contacts' resting levels in reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_s1 <= RESET_LEVEL;
            r_s2 <= RESET_LEVEL;
        end else begin
            r_s1 <= raw_in;
            r_s2 <= r_s1;
        end
    end

    // Per-channel stability counter: any agreeing sample restarts the count,
    // the STABLE_CYCLES-th consecutive differing sample commits the new level.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_clean <= RESET_LEVEL;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_rise[i] <= 1'b0;
                r_fall[i] <= 1'b0;
                if (r_s2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_clean[i] <= r_s2[i];
                    r_cnt[i]   <= '0;
                    r_rise[i]  <= r_s2[i];
                    r_fall[i]  <= ~r_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign clean_out  = r_clean;
    assign rise_pulse = r_rise;
    assign fall_pulse = r_fall;

`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
    logic [CHANNELS-1:0] w_abort;
    logic [7:0]          r_glitch;

    // A channel aborts when its sample agrees again while a count is pending.
    always_comb begin
        w_abort = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_abort[i] = (r_cnt[i] != '0) && (r_s2[i] == r_clean[i]);
        end
    end

    // One increment per cycle with any abort, holding at 255.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_glitch <= 8'h00;
        end else if ((|w_abort) && (r_glitch != 8'hFF)) begin
            r_glitch <= r_glitch + 8'h01;
        end
    end

    assign glitch_count = r_glitch;
`else
    assign glitch_count = 8'h00;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with STABLE_CYCLES=4, CNT_W=3, RESET_LEVEL=3'b011.
// The reference model keeps the full history of levels the debouncer sees
// and decides each edge from a window over that history: the level flips when
// the last STABLE_CYCLES samples all disagree with it; an abort is a sample
// that agrees right after one that disagreed without committing.
module tb_input_conditioner;

    localparam int         CH = 3;
    localparam int         S  = 4;
    localparam int         CW = 3;
    localparam logic [2:0] RL = 3'b011;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic [CH-1:0] raw_in = 3'b100;
    logic [CH-1:0] clean_out;
    logic [CH-1:0] rise_pulse;
    logic [CH-1:0] fall_pulse;
    logic [7:0]    glitch_count;

    int checks = 0;
    int errors = 0;

    // expected {clean, rise, fall, glitch} after each edge
    logic [16:0] exp_q[$];
    logic [2:0]  hist[$];
    logic [2:0]  m_clean = RL;
    logic [7:0]  m_glitch = 8'h00;
    logic [16:0] mon_e;
    int          pulse_cnt;

    input_conditioner #(
        .CHANNELS(CH),
        .STABLE_CYCLES(S),
        .CNT_W(CW),
        .RESET_LEVEL(RL)
    ) dut (
        .clk(clk),
        .res_n(res_n),
        .raw_in(raw_in),
        .clean_out(clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .glitch_count(glitch_count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model for one clock edge; pushes the expected outputs.
    task automatic model_edge(input logic [2:0] raw, input logic rn);
        logic [2:0] rise;
        logic [2:0] fall;
        logic       abort;
        logic       all_diff;
        int         k;
        rise  = '0;
        fall  = '0;
        abort = 1'b0;
        if (!rn) begin
            hist.delete();
            hist.push_back(RL);
            hist.push_back(RL);
            m_clean  = RL;
            m_glitch = 8'h00;
        end else begin
            k = hist.size() - 2;
            for (int c = 0; c < CH; c++) begin
                if (k >= 1) begin
                    if (hist[k][c] == m_clean[c] && hist[k-1][c] != m_clean[c]) abort = 1'b1;
                end
                all_diff = (k >= S - 1);
                if (all_diff) begin
                    for (int j = 0; j < S; j++) begin
                        if (hist[k-j][c] == m_clean[c]) all_diff = 1'b0;
                    end
                end
                if (all_diff) begin
                    if (m_clean[c] == 1'b0) rise[c] = 1'b1;
                    else                    fall[c] = 1'b1;
                end
            end
            m_clean = m_clean ^ (rise | fall);
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
            if (abort && m_glitch != 8'hFF) m_glitch = m_glitch + 8'h01;
`endif
            hist.push_back(raw);
        end
        exp_q.push_back({m_clean, rise, fall, m_glitch});
    endtask

    // Driver: one clock per call; returns 2 ns after the edge.
    task automatic step(input logic [2:0] r, input logic rn);
        @(negedge clk);
        raw_in = r;
        res_n  = rn;
        model_edge(r, rn);
        @(posedge clk);
        #2;
    endtask

    task automatic hold(input logic [2:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b1);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("clean_out",    32'(clean_out),    32'(mon_e[16:14]));
            check("rise_pulse",   32'(rise_pulse),   32'(mon_e[13:11]));
            check("fall_pulse",   32'(fall_pulse),   32'(mon_e[10:8]));
            check("glitch_count", 32'(glitch_count), 32'(mon_e[7:0]));
            check("rise_fall_excl", 32'(rise_pulse & fall_pulse), 32'd0);
        end
    end

    initial begin
        int exp_glitch;
        logic [2:0] r;
        int n;
`ifdef INPUT_CONDITIONER_GLITCH_CNT_EN
        exp_glitch = 1;
`else
        exp_glitch = 0;
`endif

        // reset with raw_in = 100
        for (int i = 0; i < 3; i++) step(3'b100, 1'b0);
        check("reset_clean", 32'(clean_out), 32'h3);
        check("reset_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        check("reset_glitch", 32'(glitch_count), 32'h0);
        pulse_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(3'b011, 1'b1);
            if ((rise_pulse | fall_pulse) != 0) pulse_cnt++;
        end
        check("idle_no_pulses", 32'(pulse_cnt), 32'd0);

        // clean press and release on the button
        hold(3'b111, 5);
        check("press_not_yet", 32'(clean_out), 32'h3);
        step(3'b111, 1'b1);
        check("press_clean", 32'(clean_out), 32'h7);
        check("press_rise", 32'(rise_pulse), 32'h4);
        step(3'b111, 1'b1);
        check("press_rise_one_cycle", 32'(rise_pulse), 32'h0);
        hold(3'b011, 5);
        check("release_not_yet", 32'(fall_pulse), 32'h0);
        step(3'b011, 1'b1);
        check("release_fall", 32'(fall_pulse), 32'h4);
        check("release_clean", 32'(clean_out), 32'h3);
        hold(3'b011, 4);

        // bounce on rotary CLK then settle low
        hold(3'b011, 2);
        hold(3'b010, 2);
        hold(3'b011, 2);
        pulse_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            step(3'b010, 1'b1);
            if (fall_pulse[0]) pulse_cnt++;
            if (i == 6) check("bounce_fall_at_6", 32'(fall_pulse), 32'h1);
        end
        check("bounce_single_fall", 32'(pulse_cnt), 32'd1);

        // glitch on rotary DT, from a fresh reset
        step(3'b011, 1'b0);
        hold(3'b011, 4);
        hold(3'b001, 3);
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(3'b011, 1'b1);
            if ((rise_pulse | fall_pulse) != 0) pulse_cnt++;
        end
        check("glitch_clean", 32'(clean_out), 32'h3);
        check("glitch_no_pulses", 32'(pulse_cnt), 32'd0);
        check("glitch_count_one", 32'(glitch_count), 32'(exp_glitch));

        // simultaneous transition on all channels
        hold(3'b100, 5);
        step(3'b100, 1'b1);
        check("simul_clean", 32'(clean_out), 32'h4);
        check("simul_fall", 32'(fall_pulse), 32'h3);
        check("simul_rise", 32'(rise_pulse), 32'h4);
        hold(3'b100, 3);

        // reset in the middle of a debounce
        step(3'b011, 1'b0);
        hold(3'b011, 8);
        hold(3'b111, 4);
        step(3'b111, 1'b0);
        check("middeb_reset_clean", 32'(clean_out), 32'h3);
        pulse_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            step(3'b111, 1'b1);
            if (i < 6 && rise_pulse != 0) pulse_cnt++;
        end
        check("middeb_no_early_pulse", 32'(pulse_cnt), 32'd0);
        check("middeb_rise_at_6", 32'(rise_pulse), 32'h4);

        // randomized levels with random hold lengths and rare resets
        for (int i = 0; i < 300; i++) begin
            r = 3'($urandom_range(0, 7));
            n = $urandom_range(1, 7);
            if ($urandom_range(0, 49) == 0) step(r, 1'b0);
            hold(r, n);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
